eep_ctrl: RTL and testbench

EEP_CTRL -- requirements
Module: eep_ctrl

---
 rtl/eep_ctrl.sv | 114 +++++++++++
 tb/tb_eep_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/eep_ctrl.sv
// EEPROM access controller: single-cycle reads, and writes followed by a
// fixed-length charge-pump phase. Every output comes straight from a flop.
module eep_ctrl #(
  parameter int CHRG_CYCLES = 1500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wrt,
  input  logic [1:0]  req_addr,
  input  logic [13:0] req_data,
  output logic        busy,
  output logic        done,
  output logic [13:0] rd_val,
  output logic [1:0]  eep_addr,
  output logic [13:0] wrt_data,
  input  logic [13:0] rd_data,
  output logic        eep_cs_n,
  output logic        eep_r_w_n,
  output logic        chrg_pmp_en
);

  typedef enum logic [1:0] {IDLE, RD, WR, CHRG} state_t;

  localparam logic [20:0] CNT_INIT = 21'(CHRG_CYCLES - 1);

  state_t      state, nxt_state;
  logic [20:0] cnt, nxt_cnt;
  logic        nxt_busy, nxt_done, nxt_cs_n, nxt_r_w_n, nxt_chrg;
  logic [13:0] nxt_rd_val, nxt_wrt_data;
  logic [1:0]  nxt_eep_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_val      <= '0;
      eep_addr    <= '0;
      wrt_data    <= '0;
      eep_cs_n    <= 1'b1;
      eep_r_w_n   <= 1'b1;
      chrg_pmp_en <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      busy        <= nxt_busy;
      done        <= nxt_done;
      rd_val      <= nxt_rd_val;
      eep_addr    <= nxt_eep_addr;
      wrt_data    <= nxt_wrt_data;
      eep_cs_n    <= nxt_cs_n;
      eep_r_w_n   <= nxt_r_w_n;
      chrg_pmp_en <= nxt_chrg;
    end
  end

  // Outputs are registered, so this block computes their value for the next
  // state rather than decoding the current one.
  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    nxt_busy     = busy;
    nxt_done     = 1'b0;
    nxt_rd_val   = rd_val;
    nxt_eep_addr = eep_addr;
    nxt_wrt_data = wrt_data;
    nxt_cs_n     = 1'b1;
    nxt_r_w_n    = 1'b1;
    nxt_chrg     = chrg_pmp_en;
    case (state)
      IDLE: begin
        if (req_rd) begin
          nxt_state    = RD;
          nxt_busy     = 1'b1;
          nxt_cs_n     = 1'b0;
          nxt_eep_addr = req_addr;
        end else if (req_wrt) begin
          nxt_state    = WR;
          nxt_busy     = 1'b1;
          nxt_cs_n     = 1'b0;
          nxt_r_w_n    = 1'b0;
          nxt_chrg     = 1'b1;
          nxt_eep_addr = req_addr;
          nxt_wrt_data = req_data;
        end
      end
      RD: begin
        nxt_state  = IDLE;
        nxt_busy   = 1'b0;
        nxt_done   = 1'b1;
        nxt_rd_val = rd_data;
      end
      WR: begin
        nxt_state = CHRG;
        nxt_cnt   = CNT_INIT;
      end
      CHRG: begin
        // Pump stays on for CNT_INIT+1 cycles here, plus the WR cycle.
        if (cnt == '0) begin
          nxt_state = IDLE;
          nxt_busy  = 1'b0;
          nxt_done  = 1'b1;
          nxt_chrg  = 1'b0;
        end else begin
          nxt_cnt = cnt - 21'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eep_ctrl.sv
// Randomized bench for eep_ctrl: transaction-level reference memory plus an
// EEPROM model that only commits a write after a full-length pump pulse.
module tb_eep_ctrl;

  localparam int C = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wrt;
  logic [1:0]  req_addr;
  logic [13:0] req_data;
  logic        busy, done;
  logic [13:0] rd_val;
  logic [1:0]  eep_addr;
  logic [13:0] wrt_data;
  logic [13:0] rd_data;
  logic        eep_cs_n, eep_r_w_n, chrg_pmp_en;

  int errors = 0;
  int checks = 0;

  eep_ctrl #(.CHRG_CYCLES(C)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wrt(req_wrt),
    .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
    .rd_val(rd_val), .eep_addr(eep_addr), .wrt_data(wrt_data),
    .rd_data(rd_data), .eep_cs_n(eep_cs_n), .eep_r_w_n(eep_r_w_n),
    .chrg_pmp_en(chrg_pmp_en)
  );

  always #5 clk = ~clk;

  // EEPROM model
  logic [13:0] emem [4];
  logic        pre_en = 1'b0;
  logic [1:0]  pre_a = '0;
  logic [13:0] pre_d = '0;
  logic        pend = 1'b0;
  logic [1:0]  pa = '0;
  logic [13:0] pd = '0;
  int          pump = 0;

  assign rd_data = emem[eep_addr];

  always @(posedge clk) begin
    if (pre_en) emem[pre_a] <= pre_d;
    if (!eep_cs_n && !eep_r_w_n) begin
      pend <= 1'b1; pa <= eep_addr; pd <= wrt_data; pump <= 1;
    end else if (pend) begin
      if (chrg_pmp_en) pump <= pump + 1;
      else begin
        pend <= 1'b0;
        emem[pa] <= (pump == C + 1) ? pd : ~pd;
      end
    end
  end

  // Reference state
  logic [13:0] ref_mem [4];
  bit          ref_known [4];
  logic [13:0] ref_rdval = '0;
  bit          rdval_known = 1'b1;
  logic [1:0]  ref_addr = '0;
  logic [13:0] ref_wdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_rdval();
    if (rdval_known) check("rd_val_hold", 32'(rd_val), 32'(ref_rdval));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pmp"},  32'(chrg_pmp_en), 0);
    check({tag, "_cs"},   32'(eep_cs_n), 1);
    check({tag, "_rwn"},  32'(eep_r_w_n), 1);
    check({tag, "_rdv"},  32'(rd_val), 0);
    check({tag, "_addr"}, 32'(eep_addr), 0);
    check({tag, "_wdat"}, 32'(wrt_data), 0);
  endtask

  task automatic do_read(input logic [1:0] a, input bit both);
    req_rd = 1'b1; req_wrt = both; req_addr = a; req_data = 14'($urandom);
    @(negedge clk);
    req_rd = 1'b0; req_wrt = 1'b0; req_addr = 2'($urandom);
    check("rd_cs", 32'(eep_cs_n), 0);
    check("rd_rwn", 32'(eep_r_w_n), 1);
    check("rd_busy", 32'(busy), 1);
    check("rd_addr", 32'(eep_addr), 32'(a));
    check("rd_pmp", 32'(chrg_pmp_en), 0);
    check("rd_done0", 32'(done), 0);
    check_rdval();
    ref_addr = a;
    @(negedge clk);
    check("rd_cs_end", 32'(eep_cs_n), 1);
    check("rd_rwn_end", 32'(eep_r_w_n), 1);
    check("rd_busy_end", 32'(busy), 0);
    check("rd_done", 32'(done), 1);
    if (ref_known[a]) check("rd_val", 32'(rd_val), 32'(ref_mem[a]));
    ref_rdval = ref_mem[a];
    rdval_known = ref_known[a];
    if (both) begin
      @(negedge clk);
      check("both_busy", 32'(busy), 0);
      check("both_rwn", 32'(eep_r_w_n), 1);
      check("both_pmp", 32'(chrg_pmp_en), 0);
      check("both_wdat", 32'(wrt_data), 32'(ref_wdata));
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [13:0] d,
                          input int intr, input int rst_at);
    int n;
    bit aborted;
    req_wrt = 1'b1; req_addr = a; req_data = d;
    @(negedge clk);
    req_wrt = 1'b0; req_addr = 2'($urandom); req_data = 14'($urandom);
    check("wr_cs", 32'(eep_cs_n), 0);
    check("wr_rwn", 32'(eep_r_w_n), 0);
    check("wr_pmp", 32'(chrg_pmp_en), 1);
    check("wr_busy", 32'(busy), 1);
    check("wr_addr", 32'(eep_addr), 32'(a));
    check("wr_data", 32'(wrt_data), 32'(d));
    ref_addr = a; ref_wdata = d;
    n = 1; aborted = 1'b0;
    while (chrg_pmp_en && n <= C + 5) begin
      if (n == intr) begin req_rd = 1'b1; req_wrt = 1'($urandom); end
      @(negedge clk);
      req_rd = 1'b0; req_wrt = 1'b0;
      if (!chrg_pmp_en) break;
      n++;
      check("chg_cs", 32'(eep_cs_n), 1);
      check("chg_rwn", 32'(eep_r_w_n), 1);
      check("chg_done", 32'(done), 0);
      check("chg_busy", 32'(busy), 1);
      check("chg_addr", 32'(eep_addr), 32'(a));
      check("chg_wdat", 32'(wrt_data), 32'(d));
      check_rdval();
      if (n == rst_at) begin
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        check_reset_vals("rst_hold");
        rst = 1'b0;
        aborted = 1'b1;
        ref_known[a] = 1'b0;
        ref_rdval = '0; rdval_known = 1'b1;
        ref_addr = '0; ref_wdata = '0;
        break;
      end
    end
    if (!aborted) begin
      check("pmp_len", 32'(n), 32'(C + 1));
      check("wr_done", 32'(done), 1);
      check("wr_busy_end", 32'(busy), 0);
      check("wr_pmp_end", 32'(chrg_pmp_en), 0);
      check("wr_cs_end", 32'(eep_cs_n), 1);
      ref_mem[a] = d; ref_known[a] = 1'b1;
    end
  endtask

  task automatic do_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);
      check("idle_cs", 32'(eep_cs_n), 1);
      check("idle_pmp", 32'(chrg_pmp_en), 0);
      check("idle_addr", 32'(eep_addr), 32'(ref_addr));
      check_rdval();
    end
  endtask

  initial begin
    logic [13:0] d;
    rst = 1'b1; req_rd = 1'b0; req_wrt = 1'b0; req_addr = '0; req_data = '0;
    for (int i = 0; i < 4; i++) begin
      d = (i == 2) ? 14'h1A5C : 14'($urandom);
      ref_mem[i] = d; ref_known[i] = 1'b1;
      @(negedge clk);
      pre_en = 1'b1; pre_a = 2'(i); pre_d = d;
    end
    @(negedge clk);
    pre_en = 1'b0;
    req_rd = 1'b1; req_wrt = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");
    req_rd = 1'b0; req_wrt = 1'b0;
    rst = 1'b0;

    do_read(2'd2, 1'b0);
    do_write(2'd1, 14'h2F0F, -1, -1);
    do_read(2'd1, 1'b0);
    do_read(2'd3, 1'b1);
    do_write(2'd2, 14'($urandom), C / 2, -1);
    do_write(2'd0, 14'h0ABC, -1, -1);
    do_read(2'd0, 1'b0);
    do_write(2'd3, 14'($urandom), -1, 20);
    do_idle(2);
    do_write(2'd3, 14'h3333, 2, -1);
    do_read(2'd3, 1'b0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(3, 0))
        0: do_read(2'($urandom), 1'b0);
        1: do_write(2'($urandom), 14'($urandom),
                    ($urandom_range(1, 0) != 0) ? int'($urandom_range(C + 1, 2)) : -1, -1);
        2: do_read(2'($urandom), 1'b1);
        default: do_idle(int'($urandom_range(3, 1)));
      endcase
    end
    for (int i = 0; i < 4; i++) do_read(2'(i), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
